fu_issue_arbiter: RTL and testbench
===================================

// Module: fu_issue_arbiter
// PURPOSE
//  Parametrised, registered issue stage between the reservation stations and the functional units.
//  Each cycle, every FU picks the oldest ready RS entry it can execute; oldest means closest to the ROB head.
//  Each FU accepts at most one entry, and each entry is granted to at most one FU.
//  Issued ops are held in one pipeline register per FU behind a valid/ready handshake.
//  Supports flush and per-FU backpressure stall counters.
// PARAMETERS
//  NUM_RS    4   reservation-station entries presented per cycle
//  NUM_FU    5   functional units (0,1 ALU; 2 MUL; 3 DIV; 4 SHIFT in default build)
//  XLEN      32  operand width
//  ROB_W     4   ROB index width; the ROB holds 2**ROB_W entries
//  OP_W      4   ALU_op width
//  CTRL_W    4   side-band control {load, branch_type[2:0]}
//  CNT_W     16  stall-counter width
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high reset
//  flush          in   1              squash: drop all pending issues
//  rob_head       in   ROB_W          index of the oldest ROB entry
//  rs_valid       in   NUM_RS         entry has both operands valid
//  rs_fu_mask     in   NUM_RS*NUM_FU  bit [i][f] set = entry i may run on FU f
//  rs_op          in   NUM_RS*OP_W    ALU_op per entry
//  rs_src1/src2   in   NUM_RS*XLEN    operand values
//  rs_rob         in   NUM_RS*ROB_W   ROB entry per entry
//  rs_ctrl        in   NUM_RS*CTRL_W  load/branch_type side-band
//  rs_consumed    out  NUM_RS         combinational grant; the RS frees the entry at the next edge
//  fu_valid       out  NUM_FU         issue register holds an op
//  fu_ready       in   NUM_FU         FU accepts the op this cycle
//  fu_op          out  NUM_FU*OP_W    registered payload
//  fu_src1/src2   out  NUM_FU*XLEN    registered payload
//  fu_rob         out  NUM_FU*ROB_W   registered payload
//  fu_ctrl        out  NUM_FU*CTRL_W  registered payload
//  fu_stall_cnt   out  NUM_FU*CNT_W   cycles with fu_valid && !fu_ready, saturating
// BEHAVIOUR
//  - Reset (async): fu_valid, all payloads and fu_stall_cnt = 0; rs_consumed = 0 while reset is high.
//  - Age: age_i = (rs_rob[i] - rob_head) mod 2**ROB_W; smaller is older, so it wraps correctly across ROB wrap.
//    On equal ages, the lower index wins.
//  - slot_free[f] = !fu_valid[f] || fu_ready[f].
//  - Selection, evaluated for FU 0 then 1 .. NUM_FU-1:
//    FU f grants the oldest entry i with rs_valid[i] && rs_fu_mask[i][f], not granted to a lower FU,
//    provided slot_free[f] && !flush.
//  - Two ALU-capable FUs therefore take the oldest and second-oldest eligible entries.
//  - rs_consumed[i] = 1 iff entry i is granted this cycle; at most one FU per entry.
//  - Latency: grant in cycle N -> fu_valid[f]=1 with the payload in cycle N+1.
//  - Handshake: transfer when fu_valid && fu_ready.
//    While fu_valid && !fu_ready, the payload is held bit-stable and no new grant goes to f.
//    On a transfer with a same-cycle grant, the register reloads back-to-back with no bubble.
//  - Transfer without a new grant -> fu_valid[f]=0 next cycle.
//  - fu_ready while !fu_valid is ignored.
//  - flush (synchronous, highest priority): rs_consumed = 0 that cycle; all fu_valid = 0 next cycle.
//    Payloads are don't-care; stall counters keep their values.
//  - Counters: fu_stall_cnt[f] += 1 each cycle fu_valid[f] && !fu_ready[f] && !flush; holds at 2**CNT_W-1.
//  - No entry is lost or duplicated: every rs_consumed pulse maps to exactly one fu_valid rising or reload,
//    unless a flush intervenes.
//  - A grant with multiple mask bits set binds to one FU only; mask = 0 is never granted.
// STRUCTURE
//  - Shared package issue_pkg: rs_issue_t (op, src1, src2, rob, ctrl); FU index constants
//    (FU_ALU0, FU_ALU1, FU_MUL, FU_DIV, FU_SHIFT); helper function rob_age(rob, head).
//    ALU_op enum stays in structs.svh.
//  - Sub-module oldest_select #(NUM_RS, ROB_W): combinational; inputs eligible mask + ages, output one-hot
//    pick. Instantiated once per FU (generate loop), with already-granted entries masked out in a chain.
//  - Top: generate loop of per-FU issue registers + stall counters.
// TESTING
//  - Reset mid-issue: fu_valid[0]=1, assert reset -> fu_valid=0 and counters 0 immediately (async),
//    no rs_consumed.
//  - Age pick across wrap: rob_head=14, entries rob={15,2,14,1}, all ALU-capable, ALU ready
//    -> FU0 gets rob 14 (idx2), FU1 gets rob 15 (idx0); rs_consumed=4'b0101.
//  - Backpressure: MUL entry issued, fu_ready[2]=0 for 3 cycles -> payload stable, no 2nd MUL grant,
//    fu_stall_cnt[2]=3; ready=1 with a new MUL pending -> back-to-back reload.
//  - Class routing: entries {DIV rob3, SLL rob1, MUL rob2, ADD rob0}, all free
//    -> FU3<-rob3, FU4<-rob1, FU2<-rob2, FU0<-rob0, FU1 idle; rs_consumed=4'b1111.
//  - Flush: flush with all RS valid and all fu_valid=1 -> rs_consumed=0; next cycle all fu_valid=0.
//  - Saturation: CNT_W=4, stall FU0 for 20 cycles -> fu_stall_cnt[0]=15.

Source files
------------

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared definitions for the FU issue arbiter.
//  - rs_issue_t : one issued op (default-width build) as seen by an FU
//  - FU_*       : functional-unit index map of the default five-FU build
//  - rob_age()  : distance of a ROB index from the ROB head, modulo the ROB size
package fu_issue_arbiter_pkg;

  // Widest ROB index rob_age() can handle.
  localparam int ROB_W_MAX = 16;

  // Functional-unit slots in the default build.
  localparam int FU_ALU0  = 0;
  localparam int FU_ALU1  = 1;
  localparam int FU_MUL   = 2;
  localparam int FU_DIV   = 3;
  localparam int FU_SHIFT = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  rob;
    logic [3:0]  ctrl;
  } rs_issue_t;

  // Age of a ROB entry relative to the head; 0 is the oldest. Masking to
  // rob_w bits makes the subtraction wrap with the ROB pointer.
  function automatic logic [ROB_W_MAX-1:0] rob_age(
    input logic [ROB_W_MAX-1:0] rob,
    input logic [ROB_W_MAX-1:0] head,
    input int unsigned          rob_w
  );
    logic [ROB_W_MAX-1:0] mask;
    mask = (ROB_W_MAX'(1) << rob_w) - ROB_W_MAX'(1);
    return (rob - head) & mask;
  endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Issue-stage bus between reservation stations / FUs (master side) and the
// arbiter (slave side).
//  RS side  : flush, rob_head, rs_valid, rs_fu_mask[i*NUM_FU+f], rs_op,
//             rs_src1, rs_src2, rs_rob, rs_ctrl in; rs_consumed out
//  FU side  : fu_valid, fu_op, fu_src1, fu_src2, fu_rob, fu_ctrl,
//             fu_stall_cnt out; fu_ready in
// All multi-lane fields are flattened, lane k at [k*W +: W].
interface fu_issue_arbiter_if #(
  parameter int NUM_RS = 4,
  parameter int NUM_FU = 5,
  parameter int XLEN   = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 4,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) ();

  logic                       flush;
  logic [ROB_W-1:0]           rob_head;
  logic [NUM_RS-1:0]          rs_valid;
  logic [NUM_RS*NUM_FU-1:0]   rs_fu_mask;
  logic [NUM_RS*OP_W-1:0]     rs_op;
  logic [NUM_RS*XLEN-1:0]     rs_src1;
  logic [NUM_RS*XLEN-1:0]     rs_src2;
  logic [NUM_RS*ROB_W-1:0]    rs_rob;
  logic [NUM_RS*CTRL_W-1:0]   rs_ctrl;
  logic [NUM_RS-1:0]          rs_consumed;

  logic [NUM_FU-1:0]          fu_valid;
  logic [NUM_FU-1:0]          fu_ready;
  logic [NUM_FU*OP_W-1:0]     fu_op;
  logic [NUM_FU*XLEN-1:0]     fu_src1;
  logic [NUM_FU*XLEN-1:0]     fu_src2;
  logic [NUM_FU*ROB_W-1:0]    fu_rob;
  logic [NUM_FU*CTRL_W-1:0]   fu_ctrl;
  logic [NUM_FU*CNT_W-1:0]    fu_stall_cnt;

  modport master (
    output flush, rob_head, rs_valid, rs_fu_mask, rs_op, rs_src1, rs_src2,
           rs_rob, rs_ctrl, fu_ready,
    input  rs_consumed, fu_valid, fu_op, fu_src1, fu_src2, fu_rob, fu_ctrl,
           fu_stall_cnt
  );

  modport slave (
    input  flush, rob_head, rs_valid, rs_fu_mask, rs_op, rs_src1, rs_src2,
           rs_rob, rs_ctrl, fu_ready,
    output rs_consumed, fu_valid, fu_op, fu_src1, fu_src2, fu_rob, fu_ctrl,
           fu_stall_cnt
  );

endinterface

// File: rtl/fu_issue_arbiter_oldest_select.sv
// Combinational oldest-entry picker.
//  eligible : entries that may be chosen
//  ages     : per-entry age, lane i at [i*ROB_W +: ROB_W]; smaller is older
//  pick     : one-hot choice (all zero when nothing is eligible)
// Entry i wins when no other eligible entry is strictly older and no
// lower-indexed eligible entry has the same age. That is a total order, so
// exactly one eligible entry wins.
module fu_issue_arbiter_oldest_select #(
  parameter int NUM_RS = 4,
  parameter int ROB_W  = 4
) (
  input  logic [NUM_RS-1:0]       eligible,
  input  logic [NUM_RS*ROB_W-1:0] ages,
  output logic [NUM_RS-1:0]       pick
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : gen_pick
      logic [NUM_RS-1:0] beats;
      for (gj = 0; gj < NUM_RS; gj++) begin : gen_cmp
        if (gj < gi) begin : gen_lower
          // Lower index wins ties, so gi must be strictly older.
          assign beats[gj] = !eligible[gj] ||
                             (ages[gi*ROB_W +: ROB_W] < ages[gj*ROB_W +: ROB_W]);
        end else if (gj == gi) begin : gen_self
          assign beats[gj] = 1'b1;
        end else begin : gen_higher
          assign beats[gj] = !eligible[gj] ||
                             (ages[gi*ROB_W +: ROB_W] <= ages[gj*ROB_W +: ROB_W]);
        end
      end
      assign pick[gi] = eligible[gi] && (&beats);
    end
  endgenerate

endmodule

// File: rtl/fu_issue_arbiter.sv
// Registered issue stage between the reservation stations and the FUs.
// Each cycle FU 0..NUM_FU-1, in order, grants the oldest ready RS entry it can
// execute that no lower FU took this cycle, provided its issue register is free
// (empty or draining) and there is no flush. The granted op lands in the FU's
// issue register at the next edge and is held there until fu_ready.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : fu_issue_arbiter_if.slave (RS inputs, rs_consumed grant,
//               per-FU valid/ready payload registers, saturating stall counters)
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int NUM_RS = 4,
  parameter int NUM_FU = 5,
  parameter int XLEN   = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 4,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  fu_issue_arbiter_if.slave bus
);

  // Packed payload layout: {op, src1, src2, rob, ctrl}.
  localparam int PAY_W = OP_W + 2 * XLEN + ROB_W + CTRL_W;

  logic [NUM_RS*ROB_W-1:0]  ages;
  logic [NUM_RS*PAY_W-1:0]  rs_pay;
  logic                     issue_en;
  logic [NUM_RS-1:0]        consumed_w;
  logic [NUM_FU-1:0]        fu_valid_w;
  logic [NUM_FU*OP_W-1:0]   fu_op_w;
  logic [NUM_FU*XLEN-1:0]   fu_src1_w;
  logic [NUM_FU*XLEN-1:0]   fu_src2_w;
  logic [NUM_FU*ROB_W-1:0]  fu_rob_w;
  logic [NUM_FU*CTRL_W-1:0] fu_ctrl_w;
  logic [NUM_FU*CNT_W-1:0]  fu_cnt_w;

  // Nothing is granted during flush or while reset is held.
  assign issue_en = !bus.flush && !reset;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : gen_rs
      assign ages[gi*ROB_W +: ROB_W] = ROB_W'(rob_age(
        ROB_W_MAX'(bus.rs_rob[gi*ROB_W +: ROB_W]),
        ROB_W_MAX'(bus.rob_head),
        ROB_W));
      assign rs_pay[gi*PAY_W +: PAY_W] = {
        bus.rs_op[gi*OP_W +: OP_W],
        bus.rs_src1[gi*XLEN +: XLEN],
        bus.rs_src2[gi*XLEN +: XLEN],
        bus.rs_rob[gi*ROB_W +: ROB_W],
        bus.rs_ctrl[gi*CTRL_W +: CTRL_W]};
    end

    for (gi = 0; gi < NUM_FU; gi++) begin : gen_fu
      logic [NUM_RS-1:0] mask_col;   // entries able to run on this FU
      logic [NUM_RS-1:0] taken_in;   // entries granted to lower FUs this cycle
      logic [NUM_RS-1:0] taken_out;
      logic [NUM_RS-1:0] eligible;
      logic [NUM_RS-1:0] pick;
      logic              slot_free;
      logic [PAY_W-1:0]  pick_pay;
      logic              valid_q, valid_d;
      logic [PAY_W-1:0]  pay_q, pay_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;

      for (gj = 0; gj < NUM_RS; gj++) begin : gen_mask
        assign mask_col[gj] = bus.rs_fu_mask[gj*NUM_FU + gi];
      end

      if (gi == 0) begin : gen_chain_first
        assign taken_in = '0;
      end else begin : gen_chain_next
        assign taken_in = gen_fu[gi-1].taken_out;
      end

      // Draining register (valid && ready) may reload in the same cycle.
      assign slot_free = !valid_q || bus.fu_ready[gi];
      assign eligible  = (slot_free && issue_en) ?
                         (bus.rs_valid & mask_col & ~taken_in) : '0;
      assign taken_out = taken_in | pick;

      fu_issue_arbiter_oldest_select #(
        .NUM_RS (NUM_RS),
        .ROB_W  (ROB_W)
      ) u_select (
        .eligible (eligible),
        .ages     (ages),
        .pick     (pick)
      );

      always_comb begin
        pick_pay = '0;
        for (int i = 0; i < NUM_RS; i++) begin
          if (pick[i]) begin
            pick_pay = pick_pay | rs_pay[i*PAY_W +: PAY_W];
          end
        end
      end

      always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
          valid_d = 1'b0;
        end else if (|pick) begin
          valid_d = 1'b1;
          pay_d   = pick_pay;
        end else if (valid_q && bus.fu_ready[gi]) begin
          valid_d = 1'b0;
        end
        if (valid_q && !bus.fu_ready[gi] && !bus.flush && !(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          pay_q   <= '0;
          cnt_q   <= '0;
        end else begin
          valid_q <= valid_d;
          pay_q   <= pay_d;
          cnt_q   <= cnt_d;
        end
      end

      assign fu_valid_w[gi]                = valid_q;
      assign fu_ctrl_w[gi*CTRL_W +: CTRL_W] = pay_q[0 +: CTRL_W];
      assign fu_rob_w[gi*ROB_W +: ROB_W]    = pay_q[CTRL_W +: ROB_W];
      assign fu_src2_w[gi*XLEN +: XLEN]     = pay_q[CTRL_W+ROB_W +: XLEN];
      assign fu_src1_w[gi*XLEN +: XLEN]     = pay_q[CTRL_W+ROB_W+XLEN +: XLEN];
      assign fu_op_w[gi*OP_W +: OP_W]       = pay_q[CTRL_W+ROB_W+2*XLEN +: OP_W];
      assign fu_cnt_w[gi*CNT_W +: CNT_W]    = cnt_q;
    end
  endgenerate

  // The last FU's chain output is the set of entries granted anywhere.
  assign consumed_w = gen_fu[NUM_FU-1].taken_out;

  assign bus.rs_consumed  = consumed_w;
  assign bus.fu_valid     = fu_valid_w;
  assign bus.fu_op        = fu_op_w;
  assign bus.fu_src1      = fu_src1_w;
  assign bus.fu_src2      = fu_src2_w;
  assign bus.fu_rob       = fu_rob_w;
  assign bus.fu_ctrl      = fu_ctrl_w;
  assign bus.fu_stall_cnt = fu_cnt_w;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
module tb_fu_issue_arbiter;
  import fu_issue_arbiter_pkg::*;

  localparam int NUM_RS = 4, NUM_FU = 5, XLEN = 32, ROB_W = 4, OP_W = 4, CTRL_W = 4;
  localparam int ROB_N = 1 << ROB_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fu_issue_arbiter_if #(.CNT_W(16)) ifc ();
  fu_issue_arbiter_if #(.CNT_W(4))  ifs ();

  fu_issue_arbiter #(.CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(ifc));
  fu_issue_arbiter #(.CNT_W(4))  u_sat (.clk(clk), .reset(reset), .bus(ifs));

  // The narrow-counter instance sees identical stimulus.
  assign ifs.flush      = ifc.flush;
  assign ifs.rob_head   = ifc.rob_head;
  assign ifs.rs_valid   = ifc.rs_valid;
  assign ifs.rs_fu_mask = ifc.rs_fu_mask;
  assign ifs.rs_op      = ifc.rs_op;
  assign ifs.rs_src1    = ifc.rs_src1;
  assign ifs.rs_src2    = ifc.rs_src2;
  assign ifs.rs_rob     = ifc.rs_rob;
  assign ifs.rs_ctrl    = ifc.rs_ctrl;
  assign ifs.fu_ready   = ifc.fu_ready;

  int errors = 0;
  int checks = 0;

  // Stimulus state
  rs_issue_t         ent [NUM_RS];
  logic [NUM_FU-1:0] msk [NUM_RS];
  logic [NUM_RS-1:0] vld;
  logic [ROB_W-1:0]  head;
  logic              flush_i;
  logic [NUM_FU-1:0] rdy;

  // Reference model state
  bit                m_valid [NUM_FU];
  rs_issue_t         m_pay   [NUM_FU];
  int                m_cnt   [NUM_FU];
  int                m_cnt4  [NUM_FU];
  logic [NUM_RS-1:0] exp_consumed;
  int                g_idx   [NUM_FU];

  function automatic rs_issue_t dut_pay(int f);
    rs_issue_t p;
    p.op   = ifc.fu_op[f*OP_W +: OP_W];
    p.src1 = ifc.fu_src1[f*XLEN +: XLEN];
    p.src2 = ifc.fu_src2[f*XLEN +: XLEN];
    p.rob  = ifc.fu_rob[f*ROB_W +: ROB_W];
    p.ctrl = ifc.fu_ctrl[f*CTRL_W +: CTRL_W];
    return p;
  endfunction

  function automatic int dut_cnt(int f);
    return int'(ifc.fu_stall_cnt[f*16 +: 16]);
  endfunction

  function automatic int sat_cnt(int f);
    return int'(ifs.fu_stall_cnt[f*4 +: 4]);
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_RS; i++) begin
      ifc.rs_op[i*OP_W +: OP_W]       = ent[i].op;
      ifc.rs_src1[i*XLEN +: XLEN]     = ent[i].src1;
      ifc.rs_src2[i*XLEN +: XLEN]     = ent[i].src2;
      ifc.rs_rob[i*ROB_W +: ROB_W]    = ent[i].rob;
      ifc.rs_ctrl[i*CTRL_W +: CTRL_W] = ent[i].ctrl;
      ifc.rs_fu_mask[i*NUM_FU +: NUM_FU] = msk[i];
    end
    ifc.rs_valid = vld;
    ifc.rob_head = head;
    ifc.flush    = flush_i;
    ifc.fu_ready = rdy;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NUM_RS; i++) begin
      ent[i] = '0;
      msk[i] = '0;
    end
    vld = '0; head = '0; flush_i = 1'b0; rdy = '1;
  endtask

  task automatic model_clear();
    for (int f = 0; f < NUM_FU; f++) begin
      m_valid[f] = 0; m_pay[f] = '0; m_cnt[f] = 0; m_cnt4[f] = 0;
    end
  endtask

  task automatic rand_entry(int i);
    ent[i].op   = 4'($urandom);
    ent[i].src1 = $urandom;
    ent[i].src2 = $urandom;
    ent[i].rob  = 4'($urandom);
    ent[i].ctrl = 4'($urandom);
  endtask

  // Oldest-first list of entries (stable on equal age so lower index leads),
  // then each FU in order takes the first eligible entry still unclaimed.
  task automatic model_eval();
    int order [NUM_RS];
    int age   [NUM_RS];
    bit taken [NUM_RS];
    int tmp;
    for (int i = 0; i < NUM_RS; i++) begin
      order[i] = i;
      age[i]   = (int'(ent[i].rob) - int'(head) + ROB_N) % ROB_N;
      taken[i] = 0;
    end
    for (int a = 1; a < NUM_RS; a++) begin
      for (int b = a; b > 0; b--) begin
        if (age[order[b]] < age[order[b-1]]) begin
          tmp = order[b]; order[b] = order[b-1]; order[b-1] = tmp;
        end
      end
    end
    exp_consumed = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      g_idx[f] = -1;
      if (!flush_i && !reset && (!m_valid[f] || rdy[f])) begin
        for (int k = 0; k < NUM_RS; k++) begin
          if (g_idx[f] < 0 && vld[order[k]] && msk[order[k]][f] && !taken[order[k]]) begin
            g_idx[f] = order[k];
            taken[order[k]] = 1;
            exp_consumed[order[k]] = 1'b1;
          end
        end
      end
    end
  endtask

  // Advance model and DUT by one clock; returns at posedge + 1.
  task automatic tick();
    model_eval();
    for (int f = 0; f < NUM_FU; f++) begin
      if (m_valid[f] && !rdy[f] && !flush_i) begin
        if (m_cnt[f] < 65535) m_cnt[f]++;
        if (m_cnt4[f] < 15) m_cnt4[f]++;
      end
      if (flush_i) m_valid[f] = 0;
      else if (g_idx[f] >= 0) begin
        m_valid[f] = 1;
        m_pay[f] = ent[g_idx[f]];
      end else if (m_valid[f] && rdy[f]) m_valid[f] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    vld = '1;
    for (int i = 0; i < NUM_RS; i++) msk[i] = '1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.rs_consumed !== 4'b0) begin errors++; $display("FAIL reset_consumed: got %b expected 0000", ifc.rs_consumed); end
    checks++; if (ifc.fu_valid !== 5'b0) begin errors++; $display("FAIL reset_valid: got %b expected 00000", ifc.fu_valid); end
    checks++; if (ifc.fu_stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", ifc.fu_stall_cnt); end
    reset = 1'b0;
    model_clear();
    clear_inputs();
    vld = 4'b0001; msk[0] = 5'b00001; rdy = 5'b11110;
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b0001) begin errors++; $display("FAIL reset_issue_consumed: got %b expected 0001", ifc.rs_consumed); end
    tick();
    checks++; if (ifc.fu_valid !== 5'b00001) begin errors++; $display("FAIL reset_issue_valid: got %b expected 00001", ifc.fu_valid); end
    vld = '0; drive(); tick();
    checks++; if (dut_cnt(0) !== 1) begin errors++; $display("FAIL reset_pre_cnt: got %0d expected 1", dut_cnt(0)); end
    #2;
    vld = '1;
    for (int i = 0; i < NUM_RS; i++) msk[i] = '1;
    drive();
    reset = 1'b1;
    #1;
    checks++; if (ifc.fu_valid !== 5'b0) begin errors++; $display("FAIL reset_async_valid: got %b expected 00000", ifc.fu_valid); end
    checks++; if (ifc.fu_stall_cnt !== '0) begin errors++; $display("FAIL reset_async_cnt: got %h expected 0", ifc.fu_stall_cnt); end
    checks++; if (ifc.rs_consumed !== 4'b0) begin errors++; $display("FAIL reset_async_consumed: got %b expected 0000", ifc.rs_consumed); end
    model_clear();
    $display("test_reset done");
    do_reset();
  endtask

  task automatic test_age_wrap();
    rob_t_check: begin end
    do_reset();
    head = 4'd14;
    for (int i = 0; i < NUM_RS; i++) begin
      rand_entry(i);
      msk[i] = 5'b00011;
    end
    ent[0].rob = 4'd15; ent[1].rob = 4'd2; ent[2].rob = 4'd14; ent[3].rob = 4'd1;
    vld = 4'b1111;
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b0101) begin errors++; $display("FAIL age_wrap_consumed: got %b expected 0101", ifc.rs_consumed); end
    tick();
    checks++; if (ifc.fu_valid !== 5'b00011) begin errors++; $display("FAIL age_wrap_valid: got %b expected 00011", ifc.fu_valid); end
    checks++; if (dut_pay(0) !== ent[2]) begin errors++; $display("FAIL age_wrap_fu0: got rob %0d expected rob 14 (idx2)", dut_pay(0).rob); end
    checks++; if (dut_pay(1) !== ent[0]) begin errors++; $display("FAIL age_wrap_fu1: got rob %0d expected rob 15 (idx0)", dut_pay(1).rob); end
    $display("test_age_wrap done");
  endtask

  task automatic test_backpressure();
    rs_issue_t first;
    do_reset();
    rand_entry(0); ent[0].rob = 4'd3; msk[0] = 5'b00100;
    rand_entry(1); ent[1].rob = 4'd4; msk[1] = 5'b00100;
    first = ent[0];
    vld = 4'b0001; rdy = 5'b11011;
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b0001) begin errors++; $display("FAIL bp_first_consumed: got %b expected 0001", ifc.rs_consumed); end
    tick();
    vld = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      drive(); #1;
      checks++; if (ifc.rs_consumed !== 4'b0) begin errors++; $display("FAIL bp_no_grant: cycle %0d got %b expected 0000", c, ifc.rs_consumed); end
      checks++; if (ifc.fu_valid[2] !== 1'b1 || dut_pay(2) !== first) begin errors++; $display("FAIL bp_hold: cycle %0d got valid %b rob %0d src1 %h expected valid 1 rob 3 src1 %h", c, ifc.fu_valid[2], dut_pay(2).rob, dut_pay(2).src1, first.src1); end
      tick();
    end
    checks++; if (dut_cnt(2) !== 3) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 3", dut_cnt(2)); end
    rdy[2] = 1'b1;
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b0010) begin errors++; $display("FAIL bp_reload_consumed: got %b expected 0010", ifc.rs_consumed); end
    tick();
    checks++; if (ifc.fu_valid[2] !== 1'b1 || dut_pay(2) !== ent[1]) begin errors++; $display("FAIL bp_reload: got valid %b rob %0d expected valid 1 rob 4", ifc.fu_valid[2], dut_pay(2).rob); end
    checks++; if (dut_cnt(2) !== 3) begin errors++; $display("FAIL bp_cnt_hold: got %0d expected 3", dut_cnt(2)); end
    $display("test_backpressure done");
  endtask

  task automatic set_class_entries();
    for (int i = 0; i < NUM_RS; i++) rand_entry(i);
    ent[0].rob = 4'd3; msk[0] = 5'b01000;  // DIV
    ent[1].rob = 4'd1; msk[1] = 5'b10000;  // SLL
    ent[2].rob = 4'd2; msk[2] = 5'b00100;  // MUL
    ent[3].rob = 4'd0; msk[3] = 5'b00011;  // ADD
    vld = 4'b1111;
  endtask

  task automatic test_class_routing();
    do_reset();
    set_class_entries();
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b1111) begin errors++; $display("FAIL class_consumed: got %b expected 1111", ifc.rs_consumed); end
    tick();
    checks++; if (ifc.fu_valid !== 5'b11101) begin errors++; $display("FAIL class_valid: got %b expected 11101", ifc.fu_valid); end
    checks++; if (dut_pay(3).rob !== 4'd3 || dut_pay(4).rob !== 4'd1 || dut_pay(2).rob !== 4'd2 || dut_pay(0).rob !== 4'd0) begin
      errors++; $display("FAIL class_rob: got fu0..4 rob %0d %0d %0d %0d %0d expected 0 - 2 3 1", dut_pay(0).rob, dut_pay(1).rob, dut_pay(2).rob, dut_pay(3).rob, dut_pay(4).rob);
    end
    $display("test_class_routing done");
  endtask

  task automatic test_flush();
    do_reset();
    rdy = '0;
    set_class_entries();
    drive(); tick();
    clear_inputs(); rdy = '0;
    rand_entry(0); msk[0] = 5'b00011; vld = 4'b0001;
    drive(); tick();
    checks++; if (ifc.fu_valid !== 5'b11111) begin errors++; $display("FAIL flush_prefill: got %b expected 11111", ifc.fu_valid); end
    for (int i = 0; i < NUM_RS; i++) begin rand_entry(i); msk[i] = '1; end
    vld = '1; rdy = $urandom; flush_i = 1'b1;
    drive(); #1;
    checks++; if (ifc.rs_consumed !== 4'b0) begin errors++; $display("FAIL flush_consumed: got %b expected 0000", ifc.rs_consumed); end
    tick();
    flush_i = 1'b0; vld = '0; rdy = '0;
    drive(); #1;
    checks++; if (ifc.fu_valid !== 5'b0) begin errors++; $display("FAIL flush_valid: got %b expected 00000", ifc.fu_valid); end
    checks++; if (dut_cnt(0) !== 1 || dut_cnt(1) !== 0) begin errors++; $display("FAIL flush_cnt: got fu0 %0d fu1 %0d expected 1 0", dut_cnt(0), dut_cnt(1)); end
    $display("test_flush done");
  endtask

  task automatic test_saturation();
    do_reset();
    rand_entry(0); msk[0] = 5'b00001; vld = 4'b0001; rdy = 5'b11110;
    drive(); tick();
    vld = '0; drive();
    repeat (20) tick();
    checks++; if (sat_cnt(0) !== 15) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", sat_cnt(0)); end
    checks++; if (dut_cnt(0) !== 20) begin errors++; $display("FAIL sat_cnt16: got %0d expected 20", dut_cnt(0)); end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      head = 4'($urandom);
      for (int i = 0; i < NUM_RS; i++) begin
        rand_entry(i);
        msk[i] = ($urandom_range(0, 5) == 0) ? 5'b0 : 5'($urandom);
      end
      vld = 4'($urandom);
      rdy = 5'($urandom) | 5'($urandom);
      flush_i = ($urandom_range(0, 19) == 0);
      drive(); #1;
      model_eval();
      checks++; if (ifc.rs_consumed !== exp_consumed) begin errors++; $display("FAIL rand_consumed: cycle %0d got %b expected %b", cyc, ifc.rs_consumed, exp_consumed); end
      for (int f = 0; f < NUM_FU; f++) begin
        checks++; if (ifc.fu_valid[f] !== m_valid[f]) begin errors++; $display("FAIL rand_valid: cycle %0d fu %0d got %b expected %b", cyc, f, ifc.fu_valid[f], m_valid[f]); end
        if (m_valid[f]) begin
          checks++; if (dut_pay(f) !== m_pay[f]) begin errors++; $display("FAIL rand_payload: cycle %0d fu %0d got %h expected %h", cyc, f, dut_pay(f), m_pay[f]); end
        end
        checks++; if (dut_cnt(f) !== m_cnt[f] || sat_cnt(f) !== m_cnt4[f]) begin errors++; $display("FAIL rand_cnt: cycle %0d fu %0d got %0d/%0d expected %0d/%0d", cyc, f, dut_cnt(f), sat_cnt(f), m_cnt[f], m_cnt4[f]); end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    drive();
    test_reset();
    test_age_wrap();
    test_backpressure();
    test_class_routing();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
